// File: rtl/adler_pkg.sv
// Shared constants, FSM state type and modular reduction helper for the
// Adler-32 stream engine.
package adler_pkg;

   // Largest prime below 2^16; every running sum is kept below this value.
   localparam logic [15:0] ADLER_MOD    = 16'd65521;
   localparam logic [15:0] ADLER_A_INIT = 16'd1;
   localparam logic [15:0] ADLER_B_INIT = 16'd0;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   // Both inputs to the reduction are below 2*ADLER_MOD, so a single
   // conditional subtract gives the exact residue.
   function automatic logic [15:0] mod_reduce(input logic [16:0] sum);
      logic [16:0] diff;
      diff = sum - {1'b0, ADLER_MOD};
      return (sum >= {1'b0, ADLER_MOD}) ? diff[15:0] : sum[15:0];
   endfunction

endpackage

// File: rtl/adler_byte_step.sv
// Combinational single-byte Adler-32 update. A disabled lane passes the
// running {B,A} through untouched so the lanes can be chained freely.
module adler_byte_step
   import adler_pkg::*;
(
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic [7:0]  byte_i,
   input  logic        en_i,
   output logic [15:0] a_o,
   output logic [15:0] b_o
);

   logic [16:0] a_sum;
   logic [15:0] a_new;
   logic [16:0] b_sum;
   logic [15:0] b_new;

   // A' = (A + d) mod M, then B' = (B + A') mod M, bypassed when disabled.
   always_comb begin
      a_sum = {1'b0, a_i} + {9'd0, byte_i};
      a_new = mod_reduce(a_sum);
      b_sum = {1'b0, b_i} + {1'b0, a_new};
      b_new = mod_reduce(b_sum);
      a_o   = en_i ? a_new : a_i;
      b_o   = en_i ? b_new : b_i;
   end

endmodule

// File: rtl/adler32_stream.sv
// Stream Adler-32 engine: BYTES lanes per beat, per-lane enables, seed
// loading for continuation, and a valid/ready result handshake.
module adler32_stream
   import adler_pkg::*;
#(
   parameter int unsigned BYTES = 4
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               data_valid,
   output logic               data_ready,
   input  logic [8*BYTES-1:0] data,
   input  logic [BYTES-1:0]   byte_en,
   input  logic               last_data,
   input  logic               seed_load,
   input  logic [31:0]        seed,
   output logic               checksum_valid,
   input  logic               checksum_ready,
   output logic [31:0]        checksum
);

   state_e      state_q, state_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;

   logic        beat_accept;
   logic        seed_sel;
   logic [15:0] a_chain [BYTES+1];
   logic [15:0] b_chain [BYTES+1];

   assign data_ready     = (state_q == ACCUM);
   assign checksum_valid = (state_q == HOLD);
   assign checksum       = {b_q, a_q};
   assign beat_accept    = data_valid && data_ready;

   // A seed in the same cycle as a beat is applied before the beat's bytes.
   assign seed_sel   = seed_load && (state_q == ACCUM);
   assign a_chain[0] = seed_sel ? seed[15:0]  : a_q;
   assign b_chain[0] = seed_sel ? seed[31:16] : b_q;

   for (genvar i = 0; i < BYTES; i++) begin : g_lane
      adler_byte_step u_step (
         .a_i    (a_chain[i]),
         .b_i    (b_chain[i]),
         .byte_i (data[8*i +: 8]),
         .en_i   (byte_en[i]),
         .a_o    (a_chain[i+1]),
         .b_o    (b_chain[i+1])
      );
   end

   // Next-state: accumulate/seed in ACCUM, restart after the result is taken.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         ACCUM: begin
            if (beat_accept) begin
               a_d = a_chain[BYTES];
               b_d = b_chain[BYTES];
               if (last_data) begin
                  state_d = HOLD;
               end
            end else if (seed_load) begin
               a_d = seed[15:0];
               b_d = seed[31:16];
            end
         end
         HOLD: begin
            if (checksum_ready) begin
               state_d = ACCUM;
               a_d     = ADLER_A_INIT;
               b_d     = ADLER_B_INIT;
            end
         end
      endcase
   end

   // State and running sums; reset discards any message in flight.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         a_q     <= ADLER_A_INIT;
         b_q     <= ADLER_B_INIT;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

endmodule
